// File: rtl/inst_loader.sv
// Boot loader: byte stream -> 32-bit instruction memory writes, core held until done.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte and an error state.
module inst_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_Valid,
    input  logic [7:0]  In_Data,
    output logic        In_Ready,
    output logic        Wr_En,
    output logic [31:0] Wr_Addr,
    output logic [31:0] Wr_Data,
    output logic        Cpu_Hold,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word (or an empty count) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_SUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [15:0] widx_q, widx_d;
    logic [23:0] shift_q, shift_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        in_ready_q, in_ready_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        accept;
    logic [15:0] cnt_new;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        error_q, error_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        widx_d    = widx_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_new   = {cnt_q[15:8], In_Data};
        accept    = In_Valid && in_ready_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            sum_d = sum_q + In_Data;
`endif
            unique case (state_q)
                S_LEN: begin
                    if (bidx_q == 2'd0) begin
                        cnt_d  = {In_Data, 8'h00};
                        bidx_d = 2'd1;
                    end else begin
                        cnt_d   = cnt_new;
                        bidx_d  = 2'd0;
                        state_d = (cnt_new == 16'd0) ? S_FIN : S_DATA;
                    end
                end
                S_DATA: begin
                    bidx_d  = bidx_q + 2'd1;
                    shift_d = {shift_q[15:0], In_Data};
                    if (bidx_q == 2'd3) begin
                        // Words beyond memory capacity are swallowed, never wrapped.
                        if ((widx_q >> ADDR_W) == 16'd0) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = BASE_ADDR + {14'd0, widx_q, 2'b00};
                            wr_data_d = {shift_q, In_Data};
                        end
                        widx_d = widx_q + 16'd1;
                        if (widx_q == cnt_q - 16'd1) begin
                            state_d = S_FIN;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_SUM: begin
                    state_d = (sum_d == 8'd0) ? S_DONE : S_ERR;
                end
`endif
                default: begin
                end
            endcase
        end
        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) ||
                     (state_d == S_SUM);
        hold_d     = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        error_d    = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_LEN;
            cnt_q      <= 16'd0;
            bidx_q     <= 2'd0;
            widx_q     <= 16'd0;
            shift_q    <= 24'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            in_ready_q <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bidx_q     <= bidx_d;
            widx_q     <= widx_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign In_Ready = in_ready_q;
    assign Wr_En    = wr_en_q;
    assign Wr_Addr  = wr_addr_q;
    assign Wr_Data  = wr_data_q;
    assign Cpu_Hold = hold_q;
    assign Done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign Error    = error_q;
`else
    assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader against a stream-level reference model.
module tb_inst_loader;

    localparam int          AW   = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_Valid = 1'b0;
    logic [7:0]  In_Data = 8'h00;
    logic        In_Ready, Wr_En, Cpu_Hold, Done, Error;
    logic [31:0] Wr_Addr, Wr_Data;

    inst_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Data(In_Data),
        .In_Ready(In_Ready), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data), .Cpu_Hold(Cpu_Hold), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: the list of bytes accepted since the last reset.
    logic [7:0]  acc[$];
    bit          was_rst = 1;
    bit          exp_wr = 0;
    bit          took = 0;
    logic [31:0] exp_addr = BASE;
    logic [31:0] exp_data = 0;
    logic [63:0] wlog[$];

    function automatic int total_len();
        if (acc.size() < 2) return -1;
        return 2 + 4 * int'({acc[0], acc[1]}) + CS;
    endfunction

    function automatic logic [7:0] msum();
        logic [7:0] s = 8'd0;
        foreach (acc[i]) s += acc[i];
        return s;
    endfunction

    function automatic bit complete();
        return !was_rst && (acc.size() == total_len());
    endfunction

    function automatic bit m_ready();
        return !was_rst && !complete();
    endfunction

    function automatic bit m_done();
        return complete() && (CS == 0 || msum() == 8'd0);
    endfunction

    function automatic bit m_err();
        return complete() && CS == 1 && msum() != 8'd0;
    endfunction

    always @(posedge Clk) begin
        int idx, n, w;
        took = 0;
        if (Rst) begin
            acc.delete();
            was_rst  = 1;
            exp_wr   = 0;
            exp_addr = BASE;
            exp_data = 0;
        end else begin
            exp_wr = 0;
            if (In_Valid && m_ready()) begin
                acc.push_back(In_Data);
                took = 1;
                idx  = acc.size() - 1;
                if (idx >= 2) begin
                    n = int'({acc[0], acc[1]});
                    if (idx < 2 + 4 * n && (idx - 2) % 4 == 3) begin
                        w = (idx - 2) / 4;
                        if (w < (1 << AW)) begin
                            exp_wr   = 1;
                            exp_addr = BASE + 32'(4 * w);
                            exp_data = {acc[idx-3], acc[idx-2], acc[idx-1], acc[idx]};
                        end
                    end
                end
            end
            was_rst = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(In_Ready), 32'(m_ready()));
            chk("wr_en", 32'(Wr_En), 32'(exp_wr));
            chk("cpu_hold", 32'(Cpu_Hold), 32'(!m_done()));
            chk("done", 32'(Done), 32'(m_done()));
            chk("error", 32'(Error), 32'(m_err()));
            if (exp_wr || was_rst) begin
                chk("wr_addr", Wr_Addr, exp_addr);
                chk("wr_data", Wr_Data, exp_data);
            end
            if (Wr_En) wlog.push_back({Wr_Addr, Wr_Data});
        end
    end

    task automatic send(input logic [7:0] s[$], input int gap_pct);
        int budget;
        foreach (s[i]) begin
            budget = 0;
            do begin
                if ($urandom_range(99) < gap_pct) begin
                    In_Valid = 1'b0;
                    In_Data  = 8'($urandom);
                end else begin
                    In_Valid = 1'b1;
                    In_Data  = s[i];
                end
                @(posedge Clk);
                #1;
                budget++;
            end while (!took && budget < 200);
            if (!took) begin
                errors++;
                $display("FAIL send_timeout byte=%0d", i);
                break;
            end
        end
        In_Valid = 1'b0;
    endtask

    task automatic idle_valid(input int n);
        for (int i = 0; i < n; i++) begin
            In_Valid = 1'b1;
            In_Data  = 8'($urandom);
            @(posedge Clk);
            #1;
        end
        In_Valid = 1'b0;
    endtask

    task automatic rst_dut();
        Rst = 1'b1;
        In_Valid = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        wlog.delete();
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    function automatic void build(input int n, input bit bad, output logic [7:0] s[$]);
        logic [7:0] sm = 8'd0;
        s = {};
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
        if (CS == 1) begin
            foreach (s[i]) sm += s[i];
            s.push_back(8'(-sm) + 8'(bad));
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] s[$];
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk_en = 1;
        @(posedge Clk);
        #1;
        chk("rst_in_ready", 32'(In_Ready), 32'd0);
        chk("rst_hold", 32'(Cpu_Hold), 32'd1);
        chk("rst_addr", Wr_Addr, BASE);
        Rst = 1'b0;
        wlog.delete();

        // Single word, no gaps
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        if (CS == 1) s.push_back(8'hEB);
        send(s, 0);
        settle();
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_hold", 32'(Cpu_Hold), 32'd0);
        chk("t1_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            chk("t1_addr", wlog[0][63:32], 32'h0000_1000);
            chk("t1_data", wlog[0][31:0], 32'h1234_5678);
        end
        idle_valid(5);
        settle();
        chk("t1_after_nwr", 32'(wlog.size()), 32'd1);
        chk("t1_after_ready", 32'(In_Ready), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        rst_dut();
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
        send(s, 0);
        settle();
        chk("cs_err", 32'(Error), 32'd1);
        chk("cs_done", 32'(Done), 32'd0);
        chk("cs_hold", 32'(Cpu_Hold), 32'd1);
`endif

        // Empty image
        rst_dut();
        s = '{8'h00, 8'h00};
        if (CS == 1) s.push_back(8'h00);
        send(s, 0);
        settle();
        chk("n0_done", 32'(Done), 32'd1);
        chk("n0_nwr", 32'(wlog.size()), 32'd0);

        // Three words with gaps
        rst_dut();
        build(3, 0, s);
        send(s, 40);
        settle();
        chk("n3_nwr", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("n3_a0", wlog[0][63:32], 32'h0000_1000);
            chk("n3_a1", wlog[1][63:32], 32'h0000_1004);
            chk("n3_a2", wlog[2][63:32], 32'h0000_1008);
        end
        idle_valid(4);

        // Image longer than memory: extra words consumed, not written
        rst_dut();
        build(10, 0, s);
        send(s, 20);
        settle();
        chk("cap_nwr", 32'(wlog.size()), 32'd8);
        chk("cap_done", 32'(Done), 32'd1);
        if (wlog.size() == 8)
            chk("cap_last", wlog[7][63:32], 32'h0000_101C);

        // Reset in the middle of a word, with the 4th byte presented
        rst_dut();
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send(s, 0);
        Rst = 1'b1;
        In_Valid = 1'b1;
        In_Data = 8'h44;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        In_Valid = 1'b0;
        settle();
        chk("mid_nwr", 32'(wlog.size()), 32'd0);
        chk("mid_hold", 32'(Cpu_Hold), 32'd1);
        build(2, 0, s);
        send(s, 30);
        settle();
        chk("mid_reload_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2)
            chk("mid_reload_a0", wlog[0][63:32], BASE);

        // Random images
        for (int t = 0; t < 8; t++) begin
            rst_dut();
            build(int'($urandom_range(12)), ($urandom_range(3) == 0), s);
            send(s, int'($urandom_range(60)));
            idle_valid(3);
            settle();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
